// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Purpose:
//   Generic inter-stage pipeline register. Carries a control field and a data
//   field from one pipeline stage to the next, with a valid/ready handshake
//   so stalls propagate backwards. Flush kills everything held. A bubble
//   (out_valid = 0) always presents an all-zero control field.
//   With SKID = 1 a second holding register (the skid) absorbs one extra
//   entry. That lets in_ready come purely from registered state, which cuts
//   the combinational path from out_ready back to in_ready.
//
// Parameters:
//   CTRL_W  width of the control field (zeroed on bubbles)
//   DATA_W  width of the data field
//   SKID    1 = two-entry skid buffer, 0 = single register with
//           combinational in_ready
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high; clears all held entries
//   in_valid   upstream offers an entry
//   in_ready   this stage can accept an entry this cycle
//   in_ctrl    control bits from upstream
//   in_data    data from upstream
//   flush      drop all held entries and any entry offered this cycle
//   out_valid  an entry is presented downstream
//   out_ready  downstream consumes the presented entry this cycle
//   out_ctrl   control bits downstream, zero whenever out_valid = 0
//   out_data   data downstream, holds its last value when not loaded
//   occupancy  number of held entries (0..2)
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int CTRL_W = 5,
  parameter int DATA_W = 102,
  parameter int SKID   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // Main register: this is what the downstream stage sees.
  logic              r_mainValid;
  logic [CTRL_W-1:0] r_mainCtrl;
  logic [DATA_W-1:0] r_mainData;

  // Skid register: only ever filled when SKID = 1 and main is stalled.
  logic              r_skidValid;
  logic [CTRL_W-1:0] r_skidCtrl;
  logic [DATA_W-1:0] r_skidData;

  logic w_readyRaw;
  logic w_accept;
  logic w_consume;

  // Ready source depends on the buffering mode. With a skid buffer we only
  // look at our own registered state, so downstream ready never ripples
  // combinationally to upstream. Without it, a full main register can still
  // accept if downstream is draining it in the same cycle.
  generate
    if (SKID != 0) begin : g_skidReady
      assign w_readyRaw = !r_skidValid;
    end else begin : g_combReady
      assign w_readyRaw = !r_mainValid || out_ready;
    end
  endgenerate

  // Ready is forced low while reset is asserted so nothing looks accepted
  // during reset; it comes back as soon as reset drops because both the
  // valid bits are already clear by then.
  assign in_ready  = w_readyRaw && !reset;
  assign w_accept  = in_valid && in_ready;
  assign w_consume = r_mainValid && out_ready;

  // Storage update. Priority is reset, then flush, then normal flow.
  // In normal flow the main register is "free" when it is empty or being
  // consumed. A free main register is refilled from the skid first, which
  // keeps entries in acceptance order, and otherwise from the input. A
  // stalled main register diverts a newly accepted entry into the skid.
  // The skid can only be empty at that point, because in_ready is low
  // whenever it is full.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mainValid <= 1'b0;
      r_mainCtrl  <= '0;
      r_mainData  <= '0;
      r_skidValid <= 1'b0;
      r_skidCtrl  <= '0;
      r_skidData  <= '0;
    end else if (flush) begin
      r_mainValid <= 1'b0;
      r_skidValid <= 1'b0;
    end else if (!r_mainValid || w_consume) begin
      if (r_skidValid) begin
        r_mainValid <= 1'b1;
        r_mainCtrl  <= r_skidCtrl;
        r_mainData  <= r_skidData;
        r_skidValid <= 1'b0;
      end else if (w_accept) begin
        r_mainValid <= 1'b1;
        r_mainCtrl  <= in_ctrl;
        r_mainData  <= in_data;
      end else begin
        r_mainValid <= 1'b0;
      end
    end else if (w_accept && (SKID != 0)) begin
      r_skidValid <= 1'b1;
      r_skidCtrl  <= in_ctrl;
      r_skidData  <= in_data;
    end
  end

  // Control bits are masked with valid so a bubble can never fire
  // RegWrite/MemWrite/Branch/Jump in the next stage, even if stale control
  // bits are still sitting in the main register after a consume or flush.
  assign out_valid = r_mainValid;
  assign out_ctrl  = r_mainCtrl & {CTRL_W{r_mainValid}};
  assign out_data  = r_mainData;
  assign occupancy = {1'b0, r_mainValid} + {1'b0, r_skidValid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Purpose:
//   Self-checking bench for pipe_stage_reg. Two instances are driven side by
//   side: index 0 has the skid buffer (SKID = 1) and index 1 is the single
//   register with combinational ready (SKID = 0). The stimulus pushes each
//   entry it expects to see emitted into a per-instance queue. A negedge
//   monitor pops the queue whenever an instance hands an entry downstream
//   and compares the entry against the popped value. Directed checks cover
//   handshake timing, occupancy, flush and reset.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [4:0]   ctrl;
    logic [101:0] data;
  } entry_t;

  logic         clock;
  logic         reset;
  logic         flush;
  logic         inValid   [2];
  logic         inReady   [2];
  logic [4:0]   inCtrl    [2];
  logic [101:0] inData    [2];
  logic         outValid  [2];
  logic         outReady  [2];
  logic [4:0]   outCtrl   [2];
  logic [101:0] outData   [2];
  logic [1:0]   occupancy [2];

  entry_t expQ0[$];
  entry_t expQ1[$];

  int  checkCount;
  int  errorCount;
  bit  started;

  pipe_stage_reg #(.CTRL_W(5), .DATA_W(102), .SKID(1)) dutSkid (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (inValid[0]),
    .in_ready  (inReady[0]),
    .in_ctrl   (inCtrl[0]),
    .in_data   (inData[0]),
    .flush     (flush),
    .out_valid (outValid[0]),
    .out_ready (outReady[0]),
    .out_ctrl  (outCtrl[0]),
    .out_data  (outData[0]),
    .occupancy (occupancy[0])
  );

  pipe_stage_reg #(.CTRL_W(5), .DATA_W(102), .SKID(0)) dutComb (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (inValid[1]),
    .in_ready  (inReady[1]),
    .in_ctrl   (inCtrl[1]),
    .in_data   (inData[1]),
    .flush     (flush),
    .out_valid (outValid[1]),
    .out_ready (outReady[1]),
    .out_ctrl  (outCtrl[1]),
    .out_data  (outData[1]),
    .occupancy (occupancy[1])
  );

  // Free-running 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case the run wanders off.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h required %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic v, input logic [4:0] c,
                               input logic [101:0] d, input logic ordy);
    inValid[sel]  = v;
    inCtrl[sel]   = c;
    inData[sel]   = d;
    outReady[sel] = ordy;
  endtask

  task automatic pushExp(input int sel, input logic [4:0] c, input logic [101:0] d);
    entry_t e;
    e.ctrl = c;
    e.data = d;
    if (sel == 0) expQ0.push_back(e);
    else          expQ1.push_back(e);
  endtask

  task automatic clearExp(input int sel);
    if (sel == 0) expQ0.delete();
    else          expQ1.delete();
  endtask

  // Move to just after the next rising edge, where inputs are changed.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard side for one instance: every handed-off entry must match the
  // oldest outstanding expectation, and a bubble must show zero control.
  task automatic monitorPort(input int sel);
    entry_t e;
    int     qSize;
    qSize = (sel == 0) ? expQ0.size() : expQ1.size();
    if (outValid[sel] && outReady[sel]) begin
      if (qSize == 0) begin
        checkCount++;
        errorCount++;
        $display("[TB] FAIL unexpectedOut%0d: got ctrl %0h data %0h required no entry",
                 sel, outCtrl[sel], outData[sel]);
      end else begin
        e = (sel == 0) ? expQ0.pop_front() : expQ1.pop_front();
        checkOutput($sformatf("sbCtrl%0d", sel), 128'(outCtrl[sel]), 128'(e.ctrl));
        checkOutput($sformatf("sbData%0d", sel), 128'(outData[sel]), 128'(e.data));
      end
    end
    if (!outValid[sel]) begin
      checkOutput($sformatf("bubbleCtrl%0d", sel), 128'(outCtrl[sel]), 128'(0));
    end
  endtask

  // Monitor process, decoupled from stimulus; it stays quiet across reset
  // and flush cycles because those discard rather than hand off entries.
  always @(negedge clock) begin
    if (started && !reset && !flush) begin
      monitorPort(0);
      monitorPort(1);
    end
  end

  initial begin
    logic [101:0] d;
    checkCount = 0;
    errorCount = 0;
    started    = 1'b0;
    flush      = 1'b0;
    reset      = 1'b1;

    // Reset with a valid all-ones entry offered; nothing may be captured.
    for (int s = 0; s < 2; s++) applyStimulus(s, 1'b1, 5'b11111, {102{1'b1}}, 1'b0);
    tick();
    @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      checkOutput($sformatf("rstValid%0d", s), 128'(outValid[s]), 128'(0));
      checkOutput($sformatf("rstCtrl%0d", s), 128'(outCtrl[s]), 128'(0));
      checkOutput($sformatf("rstData%0d", s), 128'(outData[s]), 128'(0));
      checkOutput($sformatf("rstOcc%0d", s), 128'(occupancy[s]), 128'(0));
      checkOutput($sformatf("rstReadyLow%0d", s), 128'(inReady[s]), 128'(0));
    end
    tick();
    reset = 1'b0;
    for (int s = 0; s < 2; s++) applyStimulus(s, 1'b0, 5'b0, 102'h0, 1'b0);
    @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      checkOutput($sformatf("rstReadyUp%0d", s), 128'(inReady[s]), 128'(1));
      checkOutput($sformatf("rstValidAfter%0d", s), 128'(outValid[s]), 128'(0));
    end
    started = 1'b1;

    // Streaming: four back-to-back entries, each visible one cycle later.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 6; i++) begin
        tick();
        d = 102'h1234 + 102'(i);
        if (i < 4) begin
          applyStimulus(s, 1'b1, 5'b01011, d, 1'b1);
          pushExp(s, 5'b01011, d);
        end else begin
          applyStimulus(s, 1'b0, 5'b0, 102'h0, 1'b1);
        end
        @(negedge clock);
        if (i < 4) checkOutput($sformatf("streamReady%0d", s), 128'(inReady[s]), 128'(1));
        if (i >= 1 && i <= 4) begin
          checkOutput($sformatf("streamValid%0d", s), 128'(outValid[s]), 128'(1));
          checkOutput($sformatf("streamData%0d", s), 128'(outData[s]), 128'(102'h1234 + 102'(i - 1)));
        end
        if (i == 5) checkOutput($sformatf("streamEnd%0d", s), 128'(outValid[s]), 128'(0));
      end
    end

    // Backpressure on the skid instance: A to main, B to skid, C held.
    tick(); applyStimulus(0, 1'b1, 5'b00001, 102'hA, 1'b0); pushExp(0, 5'b00001, 102'hA);
    @(negedge clock);
    checkOutput("bpReadyA", 128'(inReady[0]), 128'(1));
    tick(); applyStimulus(0, 1'b1, 5'b00010, 102'hB, 1'b0); pushExp(0, 5'b00010, 102'hB);
    @(negedge clock);
    checkOutput("bpReadyB", 128'(inReady[0]), 128'(1));
    checkOutput("bpOccOne", 128'(occupancy[0]), 128'(1));
    checkOutput("bpDataA", 128'(outData[0]), 128'(102'hA));
    tick(); applyStimulus(0, 1'b1, 5'b00100, 102'hC, 1'b0); pushExp(0, 5'b00100, 102'hC);
    @(negedge clock);
    checkOutput("bpReadyFall", 128'(inReady[0]), 128'(0));
    checkOutput("bpOccTwo", 128'(occupancy[0]), 128'(2));
    tick();
    @(negedge clock);
    checkOutput("bpHoldReady", 128'(inReady[0]), 128'(0));
    checkOutput("bpHoldData", 128'(outData[0]), 128'(102'hA));
    tick(); applyStimulus(0, 1'b1, 5'b00100, 102'hC, 1'b1);
    @(negedge clock);
    checkOutput("bpStillFull", 128'(inReady[0]), 128'(0));
    tick();
    @(negedge clock);
    checkOutput("bpReadyRise", 128'(inReady[0]), 128'(1));
    checkOutput("bpDataB", 128'(outData[0]), 128'(102'hB));
    checkOutput("bpOccAfterMove", 128'(occupancy[0]), 128'(1));
    tick(); applyStimulus(0, 1'b0, 5'b0, 102'h0, 1'b1);
    @(negedge clock);
    checkOutput("bpDataC", 128'(outData[0]), 128'(102'hC));
    checkOutput("bpValidC", 128'(outValid[0]), 128'(1));
    tick();
    @(negedge clock);
    checkOutput("bpDrained", 128'(outValid[0]), 128'(0));
    checkOutput("bpOccZero", 128'(occupancy[0]), 128'(0));

    // Flush with both entries held and a new entry offered.
    tick(); applyStimulus(0, 1'b1, 5'b01111, 102'hD, 1'b0); pushExp(0, 5'b01111, 102'hD);
    tick(); applyStimulus(0, 1'b1, 5'b10101, 102'hE, 1'b0); pushExp(0, 5'b10101, 102'hE);
    tick(); applyStimulus(0, 1'b1, 5'b11111, 102'hF, 1'b0);
    flush = 1'b1;
    clearExp(0);
    @(negedge clock);
    checkOutput("flOccBefore", 128'(occupancy[0]), 128'(2));
    tick(); flush = 1'b0; applyStimulus(0, 1'b0, 5'b0, 102'h0, 1'b1);
    @(negedge clock);
    checkOutput("flValid", 128'(outValid[0]), 128'(0));
    checkOutput("flCtrl", 128'(outCtrl[0]), 128'(0));
    checkOutput("flOcc", 128'(occupancy[0]), 128'(0));
    tick(); tick();
    @(negedge clock);
    checkOutput("flIdle", 128'(outValid[0]), 128'(0));

    // Flush with one entry held while an entry is actually acceptable.
    tick(); applyStimulus(0, 1'b1, 5'b00011, 102'h61, 1'b0);
    tick(); applyStimulus(0, 1'b1, 5'b00111, 102'h62, 1'b0);
    flush = 1'b1;
    @(negedge clock);
    checkOutput("fl2ReadyOffered", 128'(inReady[0]), 128'(1));
    tick(); flush = 1'b0; applyStimulus(0, 1'b0, 5'b0, 102'h0, 1'b1);
    @(negedge clock);
    checkOutput("fl2Valid", 128'(outValid[0]), 128'(0));
    checkOutput("fl2Occ", 128'(occupancy[0]), 128'(0));
    tick();
    @(negedge clock);
    checkOutput("fl2Idle", 128'(outValid[0]), 128'(0));

    // Combinational ready on the single-register instance.
    tick(); applyStimulus(1, 1'b1, 5'b10010, 102'h71, 1'b1); pushExp(1, 5'b10010, 102'h71);
    @(negedge clock);
    checkOutput("cbReadyEmpty", 128'(inReady[1]), 128'(1));
    tick(); applyStimulus(1, 1'b0, 5'b0, 102'h0, 1'b0);
    @(negedge clock);
    checkOutput("cbReadyLow", 128'(inReady[1]), 128'(0));
    checkOutput("cbOccFull", 128'(occupancy[1]), 128'(1));
    tick(); applyStimulus(1, 1'b1, 5'b01100, 102'h72, 1'b1); pushExp(1, 5'b01100, 102'h72);
    @(negedge clock);
    checkOutput("cbReadyHigh", 128'(inReady[1]), 128'(1));
    checkOutput("cbDataFirst", 128'(outData[1]), 128'(102'h71));
    tick(); applyStimulus(1, 1'b0, 5'b0, 102'h0, 1'b1);
    @(negedge clock);
    checkOutput("cbValidKept", 128'(outValid[1]), 128'(1));
    checkOutput("cbDataSecond", 128'(outData[1]), 128'(102'h72));
    tick();
    @(negedge clock);
    checkOutput("cbEnd", 128'(outValid[1]), 128'(0));

    // Reset in the middle of a full stall on the skid instance.
    tick(); applyStimulus(0, 1'b1, 5'b11001, 102'h81, 1'b0); pushExp(0, 5'b11001, 102'h81);
    tick(); applyStimulus(0, 1'b1, 5'b10110, 102'h82, 1'b0); pushExp(0, 5'b10110, 102'h82);
    tick(); applyStimulus(0, 1'b0, 5'b0, 102'h0, 1'b0);
    @(negedge clock);
    checkOutput("rsOccFull", 128'(occupancy[0]), 128'(2));
    tick(); reset = 1'b1; clearExp(0);
    @(negedge clock);
    checkOutput("rsReadyLow", 128'(inReady[0]), 128'(0));
    tick(); reset = 1'b0; applyStimulus(0, 1'b0, 5'b0, 102'h0, 1'b1);
    @(negedge clock);
    checkOutput("rsValid", 128'(outValid[0]), 128'(0));
    checkOutput("rsCtrl", 128'(outCtrl[0]), 128'(0));
    checkOutput("rsData", 128'(outData[0]), 128'(0));
    checkOutput("rsOcc", 128'(occupancy[0]), 128'(0));
    tick(); tick(); tick();
    @(negedge clock);
    checkOutput("rsIdle", 128'(outValid[0]), 128'(0));

    // Every expected entry must have been handed off.
    checkOutput("drainQ0", 128'(expQ0.size()), 128'(0));
    checkOutput("drainQ1", 128'(expQ1.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
